regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Owns the single write port of register_file. Arbitrates NREQ writeback sources
//  (ALU, load, multi-cycle units) round-robin and drives one registered write per cycle.
//  Keeps a per-register busy scoreboard (set at issue, cleared at writeback).
//  Decode/issue queries it to stall on RAW hazards.
// PARAMETERS
//  NREQ   2   number of writeback requesters (2..4)
//  XLEN   32  data width
//  AW     5   register address width (2**AW registers; x0 hardwired zero)
// PORTS
//  clk              in   1          clock, rising edge
//  reset            in   1          asynchronous, active-low (0 = reset)
//  req_valid        in   NREQ       requester i has a write pending
//  req_addr         in   NREQ*AW    dest reg, requester i at [i*AW +: AW]
//  req_data         in   NREQ*XLEN  write data, requester i at [i*XLEN +: XLEN]
//  req_ready        out  NREQ       one-hot grant; handshake = valid & ready
//  rf_write_enable  out  1          to register_file.write_enable
//  rf_write_addr    out  AW         to register_file.write_addr
//  rf_write_data    out  XLEN       to register_file.write_data
//  rsv_valid        in   1          issue reserves dest reg this cycle
//  rsv_addr         in   AW         reserved register
//  query_addr1      in   AW         source reg 1 from decode
//  query_addr2      in   AW         source reg 2 from decode
//  query_busy1      out  1          query_addr1 has an outstanding producer
//  query_busy2      out  1          query_addr2 has an outstanding producer
//  busy_vec         out  2**AW      scoreboard bits, debug/perf
// BEHAVIOUR
//  Reset (reset=0, async): busy_vec=0; rf_write_enable=0; rf_write_addr=0;
//   rf_write_data=0; rr_ptr=NREQ-1, so requester 0 has top priority first.
//  Arbitration (combinational): search order rr_ptr+1, rr_ptr+2, ... (mod NREQ).
//   First requester with req_valid=1 gets req_ready=1; all others 0. No grant if none valid.
//   req_ready never asserted while reset=0.
//  Grant at rising edge N:
//   - rf_write_* register the winner's addr/data.
//   - rr_ptr <= winner index.
//  Write-port timing: rf_write_enable=1 during cycle N+1.
//   register_file commits the write at edge N+1. Latency is 1 cycle grant->enable.
//  No grant at edge N: rf_write_enable=0 in cycle N+1. addr/data hold their last values.
//  Granted addr==0: handshake completes; rf_write_enable stays 0 (x0 never written).
//  Scoreboard, per edge, for register r != 0:
//   set   if rsv_valid & rsv_addr==r
//   clear if rf_write_enable & rf_write_addr==r
//   set and clear together -> bit stays 1 (new producer wins).
//  busy_vec[0] is constant 0. A reserve of x0 is ignored.
//  query_busyK = busy_vec[query_addrK] & ~(rf_write_enable & rf_write_addr==query_addrK).
//   Matches register_file write forwarding; query of x0 always 0.
//  The block does not check for double reservation or writes to non-busy regs.
//   Writes always proceed; the bit just clears.
//  Reset asserted mid-operation: any in-flight write is dropped and all busy bits clear.
//   Issue logic must flush with it.
// TESTING
//  1 Reset: hold reset=0 with req_valid=2'b11 -> req_ready=0, rf_write_enable=0, busy_vec=0.
//  2 Single write:
//    stimulus: rsv x1 at edge 0; req0 addr=1 data=32'h12345678 granted at edge 1.
//    cycle 2:  rf_write_enable=1, rf_write_addr=1, query_busy1(x1)=0.
//    cycle 3:  busy_vec[1]=0 and register_file reads 32'h12345678.
//  3 Round-robin: both valid continuously (req0 addr 2/CAFEBABE, req1 addr 3/ABCDEF01)
//    -> grants alternate 01,10,01,10 starting with req0; no starvation.
//  4 x0: req1 addr=0 data=32'hDEADBEEF -> req_ready[1]=1; next cycle rf_write_enable=0.
//    Reading x0 returns 0.
//  5 Set/clear collision: x4 busy; writeback to x4 at the same edge as rsv x4 -> busy_vec[4]=1.
//    Another writeback to x4 -> 0.
//  6 Async reset mid-write: drop reset to 0 between edges while rf_write_enable=1 and
//    busy_vec!=0 -> outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: NREQ requesters offering one register write each to the arbiter.
// Requester i occupies slice i of each packed field.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin owner of the register file write port, plus a per-register busy scoreboard
// that decode queries for RAW hazards.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  wb,
  output logic                 rf_write_enable,
  output logic [AW-1:0]        rf_write_addr,
  output logic [XLEN-1:0]      rf_write_data,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  input  logic [AW-1:0]        query_addr1,
  input  logic [AW-1:0]        query_addr2,
  output logic                 query_busy1,
  output logic                 query_busy2,
  output logic [2**AW-1:0]     busy_vec
);

  localparam int unsigned NREG = 2**AW;
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_q;
  logic            we_q;
  logic [AW-1:0]   waddr_q;
  logic [XLEN-1:0] wdata_q;
  logic [NREG-1:0] busy_q, busy_d;

  logic [NREQ-1:0] grant;
  logic            found;
  logic [PW-1:0]   win_idx;
  logic [AW-1:0]   win_addr;
  logic [XLEN-1:0] win_data;

  // Search starts just after the last winner so every requester is reached within NREQ grants.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    win_idx  = rr_q;
    win_addr = '0;
    win_data = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && wb.req_valid[i] && (i == (32'(rr_q) + k) % NREQ)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          win_idx  = PW'(i);
          win_addr = wb.req_addr[i*AW +: AW];
          win_data = wb.req_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign wb.req_ready = reset ? grant : '0;

  // A reservation landing on the same edge as the writeback belongs to a newer producer,
  // so set takes precedence over clear.
  always_comb begin
    busy_d = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      busy_d[r] = (rsv_valid && (rsv_addr == AW'(r))) ||
                  (busy_q[r] && !(we_q && (waddr_q == AW'(r))));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q    <= PW'(NREQ - 1);
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      busy_q <= busy_d;
      // x0 grants complete the handshake but never reach the register file.
      we_q   <= found && (win_addr != '0);
      if (found) begin
        rr_q    <= win_idx;
        waddr_q <= win_addr;
        wdata_q <= win_data;
      end
    end
  end

  assign rf_write_enable = we_q;
  assign rf_write_addr   = waddr_q;
  assign rf_write_data   = wdata_q;
  assign busy_vec        = busy_q;

  // A write retiring this cycle is forwarded by the register file, so it no longer stalls.
  assign query_busy1 = busy_q[query_addr1] & ~(we_q & (waddr_q == query_addr1));
  assign query_busy2 = busy_q[query_addr2] & ~(we_q & (waddr_q == query_addr2));

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(wb.req_ready));
  a_x0_idle:      assert property (@(posedge clk) disable iff (!reset) !busy_q[0]);
  a_we_not_x0:    assert property (@(posedge clk) disable iff (!reset)
                                   we_q |-> (waddr_q != '0));

endmodule
